// File: rtl/undertale_pkg.sv
// undertale_pkg
//   Shared constants for the player-heart controller. It holds the box
//   geometry defaults, the ASCII command and echo codes, the heart colours and
//   the echo transmitter state type. It also has the clamp helper that the
//   position datapath uses.
package undertale_pkg;

    localparam int DEF_BOX_X   = 245;
    localparam int DEF_BOX_Y   = 230;
    localparam int DEF_BOX_W   = 150;
    localparam int DEF_BOX_H   = 150;
    localparam int DEF_HEART_R = 8;
    localparam int DEF_STEP    = 4;

    // Cycles TX_ACK waits for the transmitter to go busy before giving up
    localparam int ACK_TMO = 16;

    localparam logic [7:0] ASC_W  = 8'h77;
    localparam logic [7:0] ASC_S  = 8'h73;
    localparam logic [7:0] ASC_A  = 8'h61;
    localparam logic [7:0] ASC_D  = 8'h64;
    localparam logic [7:0] ASC_C  = 8'h63;
    localparam logic [7:0] ASC_M  = 8'h6d;
    localparam logic [7:0] ASC_Y  = 8'h79;
    localparam logic [7:0] ASC_SP = 8'h20;

    localparam logic [7:0] ECHO_W  = 8'h57;
    localparam logic [7:0] ECHO_S  = 8'h53;
    localparam logic [7:0] ECHO_A  = 8'h41;
    localparam logic [7:0] ECHO_D  = 8'h44;
    localparam logic [7:0] ECHO_C  = 8'h43;
    localparam logic [7:0] ECHO_M  = 8'h4d;
    localparam logic [7:0] ECHO_Y  = 8'h59;
    localparam logic [7:0] ECHO_SP = 8'h5a;

    localparam logic [11:0] COL_CYAN    = 12'h0ff;
    localparam logic [11:0] COL_MAGENTA = 12'hf0f;
    localparam logic [11:0] COL_YELLOW  = 12'hff0;
    localparam logic [11:0] COL_WHITE   = 12'hfff;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ACK  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    // Moves pos by dir*step, where dir is -1, 0 or +1. The sum is formed in 17-bit
    // signed arithmetic so that a step below zero cannot wrap. The result is then
    // clamped to the range [lo, hi].
    function automatic logic [15:0] clamp_step(
        input logic [15:0]       pos,
        input logic signed [1:0] dir,
        input int                step,
        input int                lo,
        input int                hi
    );
        logic signed [16:0] delta;
        logic signed [16:0] sum;
        case (dir)
            2'sb01:  delta = 17'(step);
            2'sb11:  delta = -17'(step);
            default: delta = '0;
        endcase
        sum = $signed({1'b0, pos}) + delta;
        if (sum < 17'(lo))
            return 16'(lo);
        else if (sum > 17'(hi))
            return 16'(hi);
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/echo_tx_sched.sv
// echo_tx_sched
//   This block holds a one-entry echo buffer, the transmit handshake FSM and the
//   counter of dropped echoes.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     i_load          1-cycle request to buffer i_load_data
//     i_load_data     echo byte
//     i_tx_idle       transmitter ready
//     o_tx_data       byte presented to the transmitter (held after send)
//     o_tx_transmit   1-cycle send request
//     o_drop_cnt      saturating count of echoes lost to a full buffer
//
//   state   | meaning
//   TX_IDLE | waiting for a buffered echo and an idle transmitter
//   TX_ACK  | sent; waiting for transmitter to report busy (timeout 16)
//   TX_BUSY | transmitter shifting out; wait for idle again
module echo_tx_sched
    import undertale_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_tx_idle,
    output logic [7:0] o_tx_data,
    output logic       o_tx_transmit,
    output logic [7:0] o_drop_cnt
);

    tx_state_t  r_state;
    logic [3:0] r_tmr;
    logic       r_buf_vld;
    logic [7:0] r_buf_data;
    logic [7:0] r_tx_data;
    logic       r_tx_transmit;
    logic [7:0] r_drop_cnt;
    logic       w_free;

    // The buffer is emptied in the same cycle that its byte is sent. A load that
    // arrives in that cycle finds room.
    assign w_free = (r_state == TX_IDLE) && r_buf_vld && i_tx_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= TX_IDLE;
            r_tmr         <= '0;
            r_buf_vld     <= 1'b0;
            r_buf_data    <= '0;
            r_tx_data     <= '0;
            r_tx_transmit <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_tx_transmit <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_free) begin
                        r_tx_data     <= r_buf_data;
                        r_tx_transmit <= 1'b1;
                        r_tmr         <= 4'(ACK_TMO - 1);
                        r_state       <= TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (!i_tx_idle)
                        r_state <= TX_BUSY;
                    else if (r_tmr == 4'd0)
                        r_state <= TX_IDLE;
                    else
                        r_tmr <= r_tmr - 4'd1;
                end
                TX_BUSY: begin
                    if (i_tx_idle)
                        r_state <= TX_IDLE;
                end
                default: r_state <= TX_IDLE;
            endcase

            if (i_load) begin
                if (!r_buf_vld || w_free) begin
                    r_buf_vld  <= 1'b1;
                    r_buf_data <= i_load_data;
                end else if (r_drop_cnt != 8'hff) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (w_free) begin
                r_buf_vld <= 1'b0;
            end
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_transmit = r_tx_transmit;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: rtl/heart_move_ctrl.sv
// heart_move_ctrl
//   Converts UART key bytes into the player-heart position and colour inside the
//   fighting box. Each accepted key is echoed through echo_tx_sched.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     i_rx_receive    strobe, i_rx_data valid
//     i_rx_data       received ASCII byte
//     i_animate       end-of-frame strobe; applies the pending moves and colour
//     i_tx_idle       transmitter ready
//     o_tx_data       echo byte
//     o_tx_transmit   1-cycle send request
//     o_cx, o_cy      heart centre
//     o_color         heart colour RGB444
//     o_drop_cnt      saturating dropped-echo count
module heart_move_ctrl
    import undertale_pkg::*;
#(
    parameter int BOX_X   = DEF_BOX_X,
    parameter int BOX_Y   = DEF_BOX_Y,
    parameter int BOX_W   = DEF_BOX_W,
    parameter int BOX_H   = DEF_BOX_H,
    parameter int HEART_R = DEF_HEART_R,
    parameter int STEP    = DEF_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rx_receive,
    input  logic [7:0]  i_rx_data,
    input  logic        i_animate,
    input  logic        i_tx_idle,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_transmit,
    output logic [15:0] o_cx,
    output logic [15:0] o_cy,
    output logic [11:0] o_color,
    output logic [7:0]  o_drop_cnt
);

    localparam int X_MIN = BOX_X + HEART_R;
    localparam int X_MAX = BOX_X + BOX_W - 1 - HEART_R;
    localparam int Y_MIN = BOX_Y + HEART_R;
    localparam int Y_MAX = BOX_Y + BOX_H - 1 - HEART_R;

    logic [15:0]       r_cx, r_cy;
    logic [11:0]       r_color;
    logic signed [1:0] r_pend_dx, r_pend_dy;
    logic              r_pend_col_vld;
    logic [11:0]       r_pend_col;

    logic              w_cmd_vld;
    logic              w_set_dx, w_set_dy, w_set_col;
    logic signed [1:0] w_dir;
    logic [11:0]       w_col;
    logic [7:0]        w_echo;

    always_comb begin
        w_cmd_vld = 1'b1;
        w_set_dx  = 1'b0;
        w_set_dy  = 1'b0;
        w_set_col = 1'b0;
        w_dir     = 2'sb00;
        w_col     = COL_WHITE;
        w_echo    = 8'h00;
        case (i_rx_data)
            ASC_W:  begin w_set_dy = 1'b1; w_dir = 2'sb11; w_echo = ECHO_W; end
            ASC_S:  begin w_set_dy = 1'b1; w_dir = 2'sb01; w_echo = ECHO_S; end
            ASC_A:  begin w_set_dx = 1'b1; w_dir = 2'sb11; w_echo = ECHO_A; end
            ASC_D:  begin w_set_dx = 1'b1; w_dir = 2'sb01; w_echo = ECHO_D; end
            ASC_C:  begin w_set_col = 1'b1; w_col = COL_CYAN;    w_echo = ECHO_C; end
            ASC_M:  begin w_set_col = 1'b1; w_col = COL_MAGENTA; w_echo = ECHO_M; end
            ASC_Y:  begin w_set_col = 1'b1; w_col = COL_YELLOW;  w_echo = ECHO_Y; end
            ASC_SP: begin w_set_col = 1'b1; w_col = COL_WHITE;   w_echo = ECHO_SP; end
            default: w_cmd_vld = 1'b0;
        endcase
    end

    // An animate strobe applies and clears the old pending state. The decode
    // writes come after it in this block, so a byte that arrives in the same
    // cycle as animate pends for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx           <= 16'(BOX_X + BOX_W / 2);
            r_cy           <= 16'(BOX_Y + BOX_H / 2);
            r_color        <= COL_WHITE;
            r_pend_dx      <= 2'sb00;
            r_pend_dy      <= 2'sb00;
            r_pend_col_vld <= 1'b0;
            r_pend_col     <= COL_WHITE;
        end else begin
            if (i_animate) begin
                r_cx <= clamp_step(r_cx, r_pend_dx, STEP, X_MIN, X_MAX);
                r_cy <= clamp_step(r_cy, r_pend_dy, STEP, Y_MIN, Y_MAX);
                if (r_pend_col_vld)
                    r_color <= r_pend_col;
                r_pend_dx      <= 2'sb00;
                r_pend_dy      <= 2'sb00;
                r_pend_col_vld <= 1'b0;
            end
            if (i_rx_receive && w_cmd_vld) begin
                if (w_set_dx)
                    r_pend_dx <= w_dir;
                if (w_set_dy)
                    r_pend_dy <= w_dir;
                if (w_set_col) begin
                    r_pend_col_vld <= 1'b1;
                    r_pend_col     <= w_col;
                end
            end
        end
    end

    echo_tx_sched u_echo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (i_rx_receive && w_cmd_vld),
        .i_load_data   (w_echo),
        .i_tx_idle     (i_tx_idle),
        .o_tx_data     (o_tx_data),
        .o_tx_transmit (o_tx_transmit),
        .o_drop_cnt    (o_drop_cnt)
    );

    assign o_cx    = r_cx;
    assign o_cy    = r_cy;
    assign o_color = r_color;

endmodule

// File: tb/tb_heart_move_ctrl.sv
module tb_heart_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx_receive = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_animate = 1'b0;
    logic        i_tx_idle = 1'b1;
    logic [7:0]  o_tx_data;
    logic        o_tx_transmit;
    logic [15:0] o_cx, o_cy;
    logic [11:0] o_color;
    logic [7:0]  o_drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_tx   = 0;
    logic below_min;

    heart_move_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_receive  (i_rx_receive),
        .i_rx_data     (i_rx_data),
        .i_animate     (i_animate),
        .i_tx_idle     (i_tx_idle),
        .o_tx_data     (o_tx_data),
        .o_tx_transmit (o_tx_transmit),
        .o_cx          (o_cx),
        .o_cy          (o_cy),
        .o_color       (o_color),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample at the falling edge. Count any transmit pulse
    // seen at that point.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (o_tx_transmit) n_tx++;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data    = b;
        i_rx_receive = 1'b1;
        tick();
        i_rx_receive = 1'b0;
    endtask

    task automatic frame();
        i_animate = 1'b1;
        tick();
        i_animate = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset
        repeat (3) tick();
        chk("rst_cx", 32'(o_cx), 32'd320);
        chk("rst_cy", 32'(o_cy), 32'd305);
        chk("rst_color", 32'(o_color), 32'hfff);
        chk("rst_tx", 32'(o_tx_transmit), 32'd0);
        chk("rst_txdata", 32'(o_tx_data), 32'h00);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2: 'd' then animate, echo latency N+2
        send(8'h64);
        chk("d_tx_n1", 32'(o_tx_transmit), 32'd0);
        chk("d_cx_pend", 32'(o_cx), 32'd320);
        tick();
        chk("d_tx_n2", 32'(o_tx_transmit), 32'd1);
        chk("d_txdata", 32'(o_tx_data), 32'h44);
        frame();
        chk("d_cx", 32'(o_cx), 32'd324);
        chk("d_tx_n3", 32'(o_tx_transmit), 32'd0);
        frame();
        chk("d_cleared", 32'(o_cx), 32'd324);
        idle_wait(40);

        // 3: 'a' then 'd' in one frame, plus load-and-free in the same cycle
        send(8'h61);
        send(8'h64);
        chk("a_txdata", 32'(o_tx_data), 32'h41);
        chk("a_tx", 32'(o_tx_transmit), 32'd1);
        frame();
        chk("ad_cx", 32'(o_cx), 32'd328);
        idle_wait(40);
        chk("ad_drop", 32'(o_drop_cnt), 32'd0);

        // Byte arriving with animate pends for the next frame
        send(8'h64);
        i_rx_data    = 8'h61;
        i_rx_receive = 1'b1;
        i_animate    = 1'b1;
        tick();
        i_rx_receive = 1'b0;
        i_animate    = 1'b0;
        chk("sim_old", 32'(o_cx), 32'd332);
        frame();
        chk("sim_new", 32'(o_cx), 32'd328);
        idle_wait(40);
        chk("sim_drop", 32'(o_drop_cnt), 32'd0);

        // 4: 40 frames of 'w', top clamp
        below_min = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send(8'h77);
            frame();
            if (o_cy < 16'd238) below_min = 1'b1;
            idle_wait(18);
        end
        chk("w_cy", 32'(o_cy), 32'd238);
        chk("w_never_below", 32'(below_min), 32'd0);
        chk("w_cx", 32'(o_cx), 32'd328);
        chk("w_drop", 32'(o_drop_cnt), 32'd0);

        // Right clamp
        for (int i = 0; i < 20; i++) begin
            send(8'h64);
            frame();
            idle_wait(18);
        end
        chk("d_clamp_cx", 32'(o_cx), 32'd386);
        chk("d_clamp_cy", 32'(o_cy), 32'd238);
        idle_wait(40);

        // 5: colour with transmitter busy, drops
        i_tx_idle = 1'b0;
        n_tx = 0;
        send(8'h63);
        frame();
        chk("c_color", 32'(o_color), 32'h0ff);
        send(8'h6d);
        send(8'h79);
        chk("my_drop", 32'(o_drop_cnt), 32'd2);
        idle_wait(5);
        chk("c_waits", 32'(n_tx), 32'd0);
        i_tx_idle = 1'b1;
        tick();
        chk("c_tx", 32'(o_tx_transmit), 32'd1);
        chk("c_txdata", 32'(o_tx_data), 32'h43);
        idle_wait(40);
        chk("c_single", 32'(n_tx), 32'd1);
        frame();
        chk("y_color", 32'(o_color), 32'hff0);
        chk("y_drop_hold", 32'(o_drop_cnt), 32'd2);

        // 6: reset while in TX_BUSY
        send(8'h73);
        tick();
        chk("s_tx", 32'(o_tx_transmit), 32'd1);
        chk("s_txdata", 32'(o_tx_data), 32'h53);
        i_tx_idle = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rb_cx", 32'(o_cx), 32'd320);
        chk("rb_cy", 32'(o_cy), 32'd305);
        chk("rb_color", 32'(o_color), 32'hfff);
        chk("rb_tx", 32'(o_tx_transmit), 32'd0);
        chk("rb_txdata", 32'(o_tx_data), 32'h00);
        chk("rb_drop", 32'(o_drop_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        i_tx_idle = 1'b1;
        tick();
        n_tx = 0;
        send(8'h78);
        idle_wait(5);
        chk("x_no_echo", 32'(n_tx), 32'd0);
        frame();
        chk("x_cy", 32'(o_cy), 32'd305);
        chk("x_cx", 32'(o_cx), 32'd320);
        chk("x_color", 32'(o_color), 32'hfff);

        // Reset while transmit is high drops it at once
        send(8'h63);
        tick();
        chk("c2_tx", 32'(o_tx_transmit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("c2_tx_rst", 32'(o_tx_transmit), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        chk("c2_color", 32'(o_color), 32'hfff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
